// File: rtl/dec_counter.sv
// Loadable down-counter with programmable step, selectable underflow handling
// (wrap / saturate / auto-reload), terminal-count pulse and sticky underflow flag.
//
//   state | meaning
//   IDLE  | after reset; en ignored until the first load
//   RUN   | counting down by step on each enabled cycle
//   HALT  | saturate mode hit its terminal value; waits for ld or Rst
module dec_counter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 ld,
  input  logic [DATAWIDTH-1:0] ld_val,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] step,
  input  logic [1:0]           mode,
  output logic [DATAWIDTH-1:0] d,
  output logic                 tc,
  output logic                 uf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] rl;
  logic [DATAWIDTH:0]   nx;
  logic                 brw;
  logic                 z;

  // Extra MSB of the difference is the borrow out of the subtraction.
  assign nx  = {1'b0, d} - {1'b0, step};
  assign brw = nx[DATAWIDTH];
  assign z   = (nx[DATAWIDTH-1:0] == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      d     <= '0;
      rl    <= '0;
      tc    <= 1'b0;
      uf    <= 1'b0;
      busy  <= 1'b0;
      state <= IDLE;
    end else if (ld) begin
      d     <= ld_val;
      rl    <= ld_val;
      tc    <= 1'b0;
      uf    <= 1'b0;
      busy  <= 1'b1;
      state <= RUN;
    end else begin
      tc <= 1'b0;
      if (state == RUN && en && step != '0) begin
        case (mode)
          2'b01: begin
            if (brw || z) begin
              d     <= '0;
              tc    <= 1'b1;
              busy  <= 1'b0;
              state <= HALT;
              if (brw) uf <= 1'b1;
            end else begin
              d <= nx[DATAWIDTH-1:0];
            end
          end
          2'b10: begin
            if (brw || z) begin
              d  <= rl;
              tc <= 1'b1;
              if (brw) uf <= 1'b1;
            end else begin
              d <= nx[DATAWIDTH-1:0];
            end
          end
          default: begin
            // mode 11 behaves as wrap
            d <= nx[DATAWIDTH-1:0];
            if (brw || z) tc <= 1'b1;
            if (brw) uf <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_counter.sv
// Self-checking bench for dec_counter: per-cycle stimulus vectors carry the
// expected registered outputs, queued on drive and popped after the edge.
module tb_dec_counter;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst, ld, en;
  logic [W-1:0] ld_val, step;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         tc, uf, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         rst;
    logic         ld;
    logic [W-1:0] ldv;
    logic         en;
    logic [W-1:0] step;
    logic [1:0]   mode;
    logic [W-1:0] ed;
    logic         etc;
    logic         euf;
    logic         ebusy;
  } vec_t;

  logic [W+2:0] sb[$];

  dec_counter #(.DATAWIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .ld(ld), .ld_val(ld_val), .en(en),
    .step(step), .mode(mode), .d(d), .tc(tc), .uf(uf), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic r, input logic l, input logic [W-1:0] lv,
                              input logic e, input logic [W-1:0] s, input logic [1:0] m,
                              input logic [W-1:0] xd, input logic xtc, input logic xuf,
                              input logic xb);
    vec_t v;
    v = '{rst: r, ld: l, ldv: lv, en: e, step: s, mode: m,
          ed: xd, etc: xtc, euf: xuf, ebusy: xb};
    return v;
  endfunction

  // Applies one cycle of stimulus and queues the outputs it should produce.
  task automatic drive(input vec_t v);
    Rst    = v.rst;
    ld     = v.ld;
    ld_val = v.ldv;
    en     = v.en;
    step   = v.step;
    mode   = v.mode;
    sb.push_back({v.ed, v.etc, v.euf, v.ebusy});
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(1,0,0,1,1,0,  0,0,0,0));
    vs.push_back(mk(1,0,0,1,1,0,  0,0,0,0));
    for (int k = 0; k < 3; k++) vs.push_back(mk(0,0,0,1,1,0, 0,0,0,0));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(0,1,5,0,2,0,  5,0,0,1));
    vs.push_back(mk(0,0,0,1,2,0,  3,0,0,1));
    vs.push_back(mk(0,0,0,1,2,0,  1,0,0,1));
    vs.push_back(mk(0,0,0,1,2,0,  255,1,1,1));
    vs.push_back(mk(0,0,0,1,2,0,  253,0,1,1));
    vs.push_back(mk(0,1,9,0,2,0,  9,0,0,1));
    // mode 11 acts as wrap
    vs.push_back(mk(0,1,2,0,3,3,  2,0,0,1));
    vs.push_back(mk(0,0,0,1,3,3,  255,1,1,1));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL wrap[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_saturate();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(0,1,5,0,2,1,  5,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  3,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  1,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  0,1,1,0));
    vs.push_back(mk(0,0,0,1,2,1,  0,0,1,0));
    vs.push_back(mk(0,0,0,1,2,1,  0,0,1,0));
    vs.push_back(mk(0,1,6,0,2,1,  6,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  4,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  2,0,0,1));
    vs.push_back(mk(0,0,0,1,2,1,  0,1,0,0));
    vs.push_back(mk(0,0,0,1,2,1,  0,0,0,0));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL saturate[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reload();
    vec_t vs[$];
    logic [W+2:0] exp;
    logic [W-1:0] seq1 [8] = '{3, 2, 1, 4, 3, 2, 1, 4};
    vs.push_back(mk(0,1,4,0,1,2,  4,0,0,1));
    foreach (seq1[k]) vs.push_back(mk(0,0,0,1,1,2, seq1[k], seq1[k] == 4, 0, 1));
    vs.push_back(mk(0,1,4,0,3,2,  4,0,0,1));
    vs.push_back(mk(0,0,0,1,3,2,  1,0,0,1));
    vs.push_back(mk(0,0,0,1,3,2,  4,1,1,1));
    vs.push_back(mk(0,0,0,1,3,2,  1,0,1,1));
    vs.push_back(mk(0,0,0,1,3,2,  4,1,1,1));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL reload[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(0,1,3,0,3,2,  3,0,0,1));
    vs.push_back(mk(0,0,0,1,3,2,  3,1,0,1));
    vs.push_back(mk(0,0,0,1,3,2,  3,1,0,1));
    vs.push_back(mk(0,0,0,1,5,2,  3,1,1,1));
    vs.push_back(mk(0,0,0,0,5,2,  3,0,1,1));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_priority();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(0,1,7,1,1,0,  7,0,0,1));
    vs.push_back(mk(0,0,0,1,0,0,  7,0,0,1));
    vs.push_back(mk(0,0,0,0,1,0,  7,0,0,1));
    vs.push_back(mk(1,1,9,1,1,0,  0,0,0,0));
    vs.push_back(mk(0,1,0,0,1,0,  0,0,0,1));
    vs.push_back(mk(0,0,0,1,1,0,  255,1,1,1));
    vs.push_back(mk(0,0,0,1,1,0,  254,0,1,1));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL priority[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    vec_t vs[$];
    logic [W+2:0] exp;
    vs.push_back(mk(0,1,200,0,1,0, 200,0,0,1));
    for (int k = 1; k <= 10; k++) vs.push_back(mk(0,0,0,1,1,0, 8'(200 - k), 0, 0, 1));
    vs.push_back(mk(1,0,0,1,1,0,  0,0,0,0));
    vs.push_back(mk(0,0,0,1,1,0,  0,0,0,0));
    vs.push_back(mk(0,0,0,1,1,0,  0,0,0,0));
    foreach (vs[i]) begin
      drive(vs[i]);
      exp = sb.pop_front();
      checks++;
      if ({d, tc, uf, busy} !== exp) begin
        errors++;
        $display("FAIL reset_mid_run[%0d]: got d=%0d tc=%b uf=%b busy=%b, expected d=%0d tc=%b uf=%b busy=%b",
                 i, d, tc, uf, busy, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    Rst = 1'b1; ld = 1'b0; ld_val = '0; en = 1'b0; step = '0; mode = '0;
    #1;
    test_reset();
    test_wrap();
    test_saturate();
    test_reload();
    test_back_to_back();
    test_priority();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
